flat_shader: RTL

- Parametrised flat-shading unit for the 3D rasteriser. Sits between triangle setup and the rasteriser colour input.
- Per triangle:
  - computes the face normal as the cross product of two edge vectors;
  - takes the dot product of the normal with a runtime light-direction vector;
  - computes cos² of the incidence angle with an iterative divider;
  - maps the result to a COLOR_W-bit intensity with an ambient floor.
- One triangle in flight at a time. Valid/ready handshake on both sides.

---
 rtl/flat_shader.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/flat_shader.sv
// Flat-shading unit: face normal, N.L, cos^2 via restoring divider, ambient floor.
// FLAT_SHADER_TWO_SIDED_EN lights faces from both sides; vectors packed {x,y,z}.
module flat_shader #(
  parameter int COORD_W = 10,
  parameter int LIGHT_W = 8,
  parameter int COLOR_W = 8,
  parameter int AMBIENT = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   tri_valid_in,
  output logic                   tri_ready_out,
  input  logic [3*COORD_W-1:0]   v1_in,
  input  logic [3*COORD_W-1:0]   v2_in,
  input  logic [3*COORD_W-1:0]   v3_in,
  input  logic [3*LIGHT_W-1:0]   light_in,
  output logic                   color_valid_out,
  input  logic                   color_ready_in,
  output logic [COLOR_W-1:0]     color_out,
  output logic                   degenerate_out,
  output logic                   backface_out
);

  localparam int E_W   = COORD_W + 1;
  localparam int N_W   = 2*COORD_W + 3;
  localparam int D_W   = N_W + LIGHT_W + 2;
  localparam int M_W   = 2*N_W + 2;
  localparam int L_W   = 2*LIGHT_W + 2;
  localparam int NUM_W = 2*D_W;
  localparam int DEN_W = M_W + L_W;
  localparam int R_W   = DEN_W + 1;
  localparam int Q_W   = COLOR_W + 1;
  localparam int P_W   = COLOR_W + Q_W;
  localparam int CNT_W = $clog2(COLOR_W + 1);

  localparam logic [COLOR_W-1:0] AMB  = COLOR_W'(AMBIENT);
  localparam logic [COLOR_W-1:0] SPAN =
    COLOR_W'((1 << COLOR_W) - 1 - AMBIENT);

  typedef enum logic [2:0] {
    S_IDLE, S_EDGE, S_CROSS, S_DOT,
    S_SQ, S_DIV, S_SHADE, S_OUT
  } state_t;

  state_t state, next;
  logic   armed;
  logic   accept;

  logic [3*COORD_W-1:0] v1_q, v2_q, v3_q;
  logic [3*LIGHT_W-1:0] lt_q;

  logic signed [COORD_W-1:0] ax, ay, az;
  logic signed [COORD_W-1:0] bx, by, bz;
  logic signed [COORD_W-1:0] cx, cy, cz;
  logic signed [LIGHT_W-1:0] lx, ly, lz;

  logic signed [E_W-1:0] e1x, e1y, e1z;
  logic signed [E_W-1:0] e2x, e2y, e2z;
  logic signed [N_W-1:0] nx, ny, nz;
  logic signed [D_W-1:0] d_q;
  logic signed [M_W-1:0] m_q;
  logic signed [L_W-1:0] l_q;

  logic signed [NUM_W-1:0] num_c;
  logic [DEN_W-1:0]        den_c;
  logic [DEN_W-1:0]        den_q;
  logic [R_W-1:0]          rem;
  logic [R_W-1:0]          sh_c;
  logic                    ge_c;
  logic [Q_W-1:0]          q;
  logic [CNT_W-1:0]        cnt;
  logic                    deg_q, bf_q;

  logic [P_W-1:0]     prod_c;
  logic [COLOR_W-1:0] lit_c;
  logic               lit_en;

  logic [COLOR_W-1:0] color_q;
  logic               deg_out_q, bf_out_q;

  assign ax = v1_q[3*COORD_W-1 -: COORD_W];
  assign ay = v1_q[2*COORD_W-1 -: COORD_W];
  assign az = v1_q[COORD_W-1:0];
  assign bx = v2_q[3*COORD_W-1 -: COORD_W];
  assign by = v2_q[2*COORD_W-1 -: COORD_W];
  assign bz = v2_q[COORD_W-1:0];
  assign cx = v3_q[3*COORD_W-1 -: COORD_W];
  assign cy = v3_q[2*COORD_W-1 -: COORD_W];
  assign cz = v3_q[COORD_W-1:0];
  assign lx = lt_q[3*LIGHT_W-1 -: LIGHT_W];
  assign ly = lt_q[2*LIGHT_W-1 -: LIGHT_W];
  assign lz = lt_q[LIGHT_W-1:0];

  assign tri_ready_out   = armed && (state == S_IDLE);
  assign accept          = tri_valid_in && tri_ready_out;
  assign color_valid_out = (state == S_OUT);
  assign color_out       = color_q;
  assign degenerate_out  = deg_out_q;
  assign backface_out    = bf_out_q;

  assign num_c = NUM_W'(d_q) * NUM_W'(d_q);
  assign den_c = DEN_W'($unsigned(m_q)) * DEN_W'($unsigned(l_q));

  // First quotient bit (weight 2^COLOR_W) compares the unshifted remainder.
  assign sh_c = (cnt == '0) ? rem : {rem[R_W-2:0], 1'b0};
  assign ge_c = (sh_c >= {1'b0, den_q});

  assign prod_c = P_W'(SPAN) * P_W'(q);
  assign lit_c  = COLOR_W'(prod_c >> COLOR_W);

`ifdef FLAT_SHADER_TWO_SIDED_EN
  assign lit_en = !deg_q;
`else
  assign lit_en = !deg_q && !bf_q;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= next;
      armed <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  if (accept) next = S_EDGE;
      S_EDGE:  next = S_CROSS;
      S_CROSS: next = S_DOT;
      S_DOT:   next = S_SQ;
      S_SQ:    next = S_DIV;
      S_DIV:   if (cnt == CNT_W'(COLOR_W)) next = S_SHADE;
      S_SHADE: next = S_OUT;
      S_OUT:   if (color_ready_in) next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q      <= '0;
      v2_q      <= '0;
      v3_q      <= '0;
      lt_q      <= '0;
      e1x       <= '0;
      e1y       <= '0;
      e1z       <= '0;
      e2x       <= '0;
      e2y       <= '0;
      e2z       <= '0;
      nx        <= '0;
      ny        <= '0;
      nz        <= '0;
      d_q       <= '0;
      m_q       <= '0;
      l_q       <= '0;
      den_q     <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
      deg_q     <= 1'b0;
      bf_q      <= 1'b0;
      color_q   <= '0;
      deg_out_q <= 1'b0;
      bf_out_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            v1_q <= v1_in;
            v2_q <= v2_in;
            v3_q <= v3_in;
            lt_q <= light_in;
          end
        end
        S_EDGE: begin
          e1x <= E_W'(bx) - E_W'(ax);
          e1y <= E_W'(by) - E_W'(ay);
          e1z <= E_W'(bz) - E_W'(az);
          e2x <= E_W'(cx) - E_W'(ax);
          e2y <= E_W'(cy) - E_W'(ay);
          e2z <= E_W'(cz) - E_W'(az);
        end
        S_CROSS: begin
          nx <= N_W'(e1y) * N_W'(e2z) - N_W'(e1z) * N_W'(e2y);
          ny <= N_W'(e1z) * N_W'(e2x) - N_W'(e1x) * N_W'(e2z);
          nz <= N_W'(e1x) * N_W'(e2y) - N_W'(e1y) * N_W'(e2x);
        end
        S_DOT: begin
          d_q <= D_W'(nx) * D_W'(lx)
               + D_W'(ny) * D_W'(ly)
               + D_W'(nz) * D_W'(lz);
          m_q <= M_W'(nx) * M_W'(nx)
               + M_W'(ny) * M_W'(ny)
               + M_W'(nz) * M_W'(nz);
          l_q <= L_W'(lx) * L_W'(lx)
               + L_W'(ly) * L_W'(ly)
               + L_W'(lz) * L_W'(lz);
        end
        S_SQ: begin
          rem   <= R_W'($unsigned(num_c));
          den_q <= den_c;
          deg_q <= (m_q == '0) || (l_q == '0);
          bf_q  <= d_q[D_W-1] || (d_q == '0);
          q     <= '0;
          cnt   <= '0;
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          // A zero divisor leaves q at 0; shading falls back to ambient.
          if (!deg_q) begin
            if (ge_c) begin
              rem <= sh_c - {1'b0, den_q};
              q   <= {q[Q_W-2:0], 1'b1};
            end else begin
              rem <= sh_c;
              q   <= {q[Q_W-2:0], 1'b0};
            end
          end
        end
        S_SHADE: begin
          color_q   <= lit_en ? (AMB + lit_c) : AMB;
          deg_out_q <= deg_q;
          bf_out_q  <= bf_q;
        end
        S_OUT: begin
        end
      endcase
    end
  end

endmodule
